// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage register indices and control bits in,
// stall/flush enables and E-stage forwarding selects out; no handshake, all levels.
interface hazard_ctrl_if;
  logic [4:0] Rs1D, Rs2D;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic       MemReadE, RegWriteE;
  logic [4:0] RdM;
  logic       RegWriteM;
  logic [4:0] RdW;
  logic       RegWriteW;
  logic       PCSrcE;
  logic       MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MemTimeout;
  logic [15:0] StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, RegWriteE,
    output RdM, RegWriteM, RdW, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemTimeout, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, RegWriteE,
    input  RdM, RegWriteM, RdW, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemTimeout, StallCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// RV32I hazard controller: zero-latency stall/flush/forward decode, plus registered memory-wait
// tracking (timeout flag) and a saturating stall-cycle counter; a stalled memory access is never aborted.
module hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int COUNT_W  = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_timeout_q, mem_timeout_d;
  logic [COUNT_W-1:0]  stall_count_q, stall_count_d;

  logic       mem_wait, lw_stall;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  assign mem_wait = hz.MemReqM && !hz.MemReadyM;
  assign lw_stall = hz.MemReadE && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset) begin
      // M holds the younger result, so it wins over W
      if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E))      fwd_a = 2'b10;
      else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E)) fwd_a = 2'b01;
      if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E))      fwd_b = 2'b10;
      else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E)) fwd_b = 2'b01;
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (mem_wait) begin
      // E holds, so a redirect resolved there is replayed once the access completes
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_count_d = stall_count_q;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          if (wait_cnt_q == WAIT_MAX) mem_timeout_d = 1'b1;
          else                        wait_cnt_d    = wait_cnt_q + 1'b1;
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    if (stall_f && (stall_count_q != {COUNT_W{1'b1}}))
      stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushW     = flush_w;
  assign hz.ForwardAE  = fwd_a;
  assign hz.ForwardBE  = fwd_b;
  assign hz.MemTimeout = mem_timeout_q;
  assign hz.StallCount = 16'(stall_count_q);
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then randomized traffic, against a behavioural model
// that tracks consecutive wait cycles and total stall cycles as plain integers.
module tb_hazard_ctrl;
  localparam int MAXW = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MAX_WAIT(MAXW), .COUNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int m_run;
  bit m_timeout;
  int m_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, ForwardAE, ForwardBE}
  function automatic logic [10:0] exp_comb();
    logic [3:0] st = 4'b0000;
    logic [2:0] fl = 3'b000;
    logic [1:0] fa = 2'b00, fb = 2'b00;
    bit mw, lw;
    if (reset) return {4'b0000, 3'b111, 2'b00, 2'b00};
    if (hif.RegWriteM && hif.RdM != 0 && hif.RdM == hif.Rs1E)      fa = 2'b10;
    else if (hif.RegWriteW && hif.RdW != 0 && hif.RdW == hif.Rs1E) fa = 2'b01;
    if (hif.RegWriteM && hif.RdM != 0 && hif.RdM == hif.Rs2E)      fb = 2'b10;
    else if (hif.RegWriteW && hif.RdW != 0 && hif.RdW == hif.Rs2E) fb = 2'b01;
    mw = hif.MemReqM && !hif.MemReadyM;
    lw = hif.MemReadE && hif.RdE != 0 && (hif.RdE == hif.Rs1D || hif.RdE == hif.Rs2D);
    if (mw)              begin st = 4'b1111; fl = 3'b001; end
    else if (hif.PCSrcE) fl = 3'b110;
    else if (lw)         begin st = 4'b1100; fl = 3'b010; end
    return {st, fl, fa, fb};
  endfunction

  task automatic check_all();
    logic [10:0] e = exp_comb();
    chk("StallF", hif.StallF, e[10]);
    chk("StallD", hif.StallD, e[9]);
    chk("StallE", hif.StallE, e[8]);
    chk("StallM", hif.StallM, e[7]);
    chk("FlushD", hif.FlushD, e[6]);
    chk("FlushE", hif.FlushE, e[5]);
    chk("FlushW", hif.FlushW, e[4]);
    chk("ForwardAE", hif.ForwardAE, e[3:2]);
    chk("ForwardBE", hif.ForwardBE, e[1:0]);
    chk("MemTimeout", hif.MemTimeout, m_timeout);
    chk("StallCount", hif.StallCount, m_count);
  endtask

  task automatic model_edge();
    logic [10:0] e = exp_comb();
    bit mw = hif.MemReqM && !hif.MemReadyM;
    if (reset) begin
      m_run = 0; m_timeout = 0; m_count = 0;
    end else begin
      m_run = mw ? m_run + 1 : 0;
      // the (MAX_WAIT+1)-th consecutive waiting cycle is the first one past the budget
      if (m_run > MAXW) m_timeout = 1;
      if (e[10] && m_count < CMAX) m_count++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0; hif.RdE = 0;
    hif.MemReadE = 0; hif.RegWriteE = 0; hif.RdM = 0; hif.RegWriteM = 0;
    hif.RdW = 0; hif.RegWriteW = 0; hif.PCSrcE = 0; hif.MemReqM = 0; hif.MemReadyM = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    m_run = 0; m_timeout = 0; m_count = 0;
    clear_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("reset_count", hif.StallCount, 0);
    chk("reset_timeout", hif.MemTimeout, 0);

    // forwarding priority
    hif.RdM = 5; hif.RegWriteM = 1; hif.RdW = 5; hif.RegWriteW = 1; hif.Rs1E = 5;
    settle(); chk("fwd_a_m", hif.ForwardAE, 2'b10);
    cycle();
    hif.RdM = 0;
    settle(); chk("fwd_a_w", hif.ForwardAE, 2'b01);
    cycle();
    hif.Rs2E = 5; hif.RegWriteM = 0; hif.RegWriteW = 0;
    settle(); chk("fwd_b_off", hif.ForwardBE, 2'b00);
    cycle();

    // load-use: one bubble, then forwarded from M
    do_reset(); clear_inputs();
    hif.MemReadE = 1; hif.RdE = 7; hif.Rs2D = 7;
    settle(); chk("lu_stallf", hif.StallF, 1); chk("lu_flushe", hif.FlushE, 1);
    cycle();
    chk("lu_count", hif.StallCount, 1);
    clear_inputs(); hif.RdM = 7; hif.RegWriteM = 1; hif.Rs2E = 7;
    settle(); chk("lu_fwd", hif.ForwardBE, 2'b10); chk("lu_released", hif.StallF, 0);
    cycle();
    clear_inputs(); hif.MemReadE = 1; hif.RdE = 0;
    settle(); chk("lu_x0", hif.StallF, 0);
    cycle();

    // redirect beats load-use
    clear_inputs(); hif.MemReadE = 1; hif.RdE = 7; hif.Rs2D = 7; hif.PCSrcE = 1;
    settle();
    chk("redir_fd", hif.FlushD, 1); chk("redir_fe", hif.FlushE, 1); chk("redir_sf", hif.StallF, 0);
    cycle();

    // three wait cycles with a redirect pending
    do_reset(); clear_inputs();
    hif.MemReqM = 1; hif.MemReadyM = 0; hif.PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mw_stallm", hif.StallM, 1); chk("mw_flushw", hif.FlushW, 1); chk("mw_flushd", hif.FlushD, 0);
      cycle();
    end
    hif.MemReadyM = 1;
    settle(); chk("mw_ready_sf", hif.StallF, 0); chk("mw_ready_fd", hif.FlushD, 1);
    cycle();
    chk("mw_count", hif.StallCount, 3);
    clear_inputs();

    // timeout on the fifth edge, sticky after ready
    do_reset(); clear_inputs();
    hif.MemReqM = 1;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      chk("to_edge", hif.MemTimeout, (i >= MAXW + 1) ? 1 : 0);
    end
    hif.MemReadyM = 1;
    cycle(); cycle();
    chk("to_sticky", hif.MemTimeout, 1);

    // reset in the middle of a wait
    do_reset(); clear_inputs();
    hif.MemReqM = 1;
    for (int i = 0; i < 9; i++) cycle();
    chk("rst_pre_count", hif.StallCount, 9);
    reset = 1'b1;
    settle();
    chk("rst_fd", hif.FlushD, 1); chk("rst_fe", hif.FlushE, 1); chk("rst_fw", hif.FlushW, 1);
    chk("rst_sf", hif.StallF, 0); chk("rst_sm", hif.StallM, 0);
    cycle();
    reset = 1'b0; hif.MemReqM = 0;
    settle(); chk("rst_count", hif.StallCount, 0); chk("rst_to", hif.MemTimeout, 0);
    cycle();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      hif.Rs1D = 5'($urandom_range(0, 3)); hif.Rs2D = 5'($urandom_range(0, 3));
      hif.Rs1E = 5'($urandom_range(0, 3)); hif.Rs2E = 5'($urandom_range(0, 3));
      hif.RdE  = 5'($urandom_range(0, 3)); hif.RdM  = 5'($urandom_range(0, 3));
      hif.RdW  = 5'($urandom_range(0, 3));
      hif.MemReadE  = 1'($urandom_range(0, 1)); hif.RegWriteE = 1'($urandom_range(0, 1));
      hif.RegWriteM = 1'($urandom_range(0, 1)); hif.RegWriteW = 1'($urandom_range(0, 1));
      hif.PCSrcE    = ($urandom_range(0, 3) == 0);
      hif.MemReqM   = ($urandom_range(0, 2) != 0);
      hif.MemReadyM = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
